// File: rtl/byte_serializer_config.sv
// Shared types, sideband widths and helper functions for the AXIS byte serializer.
package byte_serializer_config;

  typedef enum logic {IDLE, SEND} ser_state_t;

  localparam int unsigned AXIS_ID_WIDTH   = 4;
  localparam int unsigned AXIS_DEST_WIDTH = 4;
  localparam int unsigned AXIS_USER_WIDTH = 1;

  localparam int unsigned DEFAULT_IN_BYTES = 2;

  // Byte-index width; a single-byte beat still keeps a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned in_bytes);
    return (in_bytes > 1) ? $clog2(in_bytes) : 1;
  endfunction

  localparam int unsigned IDX_WIDTH = idx_width(DEFAULT_IN_BYTES);

  // Processor-valid flag sits in the MSB of each input beat.
  function automatic int unsigned filler_bit(input int unsigned in_bytes);
    return in_bytes * 8 - 1;
  endfunction

endpackage

// File: rtl/axis.sv
// Generic AXI4-Stream bundle with manager (m) and subordinate (s) views.
interface axis #(
  parameter int unsigned DATA_WIDTH_BYTES = 1
);
  import byte_serializer_config::*;

  logic                          tvalid;
  logic                          tready;
  logic [DATA_WIDTH_BYTES*8-1:0] tdata;
  logic [DATA_WIDTH_BYTES-1:0]   tstrb;
  logic [DATA_WIDTH_BYTES-1:0]   tkeep;
  logic                          tlast;
  logic [AXIS_ID_WIDTH-1:0]      tid;
  logic [AXIS_DEST_WIDTH-1:0]    tdest;
  logic [AXIS_USER_WIDTH-1:0]    tuser;

  modport m (
    output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    input  tready
  );

  modport s (
    input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    output tready
  );

endinterface

// File: rtl/axis_byte_serializer.sv
// Splits multi-byte AXIS beats into a MSB-first byte stream, optionally dropping
// non-final filler beats and counting them.
module axis_byte_serializer
  import byte_serializer_config::*;
#(
  parameter int unsigned IN_BYTES  = 2,
  parameter bit          DROP_IDLE = 1'b1,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 arst,
  axis.s                       s_axis,
  axis.m                       m_axis,
  output logic [CNT_WIDTH-1:0] drop_count
);

  localparam int unsigned DataW   = IN_BYTES * 8;
  localparam int unsigned IdxW    = idx_width(IN_BYTES);
  localparam int unsigned FillBit = filler_bit(IN_BYTES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(IN_BYTES - 1);

  ser_state_t                 state_q, state_d;
  logic [IdxW-1:0]            idx_q, idx_d;
  logic [DataW-1:0]           hold_q, hold_d;
  logic                       last_q, last_d;
  logic [AXIS_ID_WIDTH-1:0]   id_q, id_d;
  logic [AXIS_DEST_WIDTH-1:0] dest_q, dest_d;
  logic [AXIS_USER_WIDTH-1:0] user_q, user_d;
  logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;

  logic at_last;
  logic byte_hs;
  logic accept;
  logic drop;

  assign at_last = (idx_q == LastIdx);
  assign byte_hs = (state_q == SEND) & m_axis.tready;

  // Input is only ready when the holding register is free or about to free up.
  assign s_axis.tready = (state_q == IDLE) | (byte_hs & at_last);
  assign accept        = s_axis.tvalid & s_axis.tready;
  assign drop          = DROP_IDLE & ~s_axis.tdata[FillBit] & ~s_axis.tlast;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    last_d  = last_q;
    id_d    = id_q;
    dest_d  = dest_q;
    user_d  = user_q;
    cnt_d   = cnt_q;

    if (byte_hs) begin
      if (!at_last) begin
        idx_d  = idx_q + 1'b1;
        hold_d = hold_q << 8;
      end else begin
        state_d = IDLE;
      end
    end

    // A load on the last-byte handshake overrides the return to IDLE.
    if (accept) begin
      if (drop) begin
        if (cnt_q != {CNT_WIDTH{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        state_d = SEND;
        idx_d   = '0;
        hold_d  = s_axis.tdata;
        last_d  = s_axis.tlast;
        id_d    = s_axis.tid;
        dest_d  = s_axis.tdest;
        user_d  = s_axis.tuser;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      last_q  <= 1'b0;
      id_q    <= '0;
      dest_q  <= '0;
      user_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      id_q    <= id_d;
      dest_q  <= dest_d;
      user_q  <= user_d;
      cnt_q   <= cnt_d;
    end
  end

  assign m_axis.tvalid = (state_q == SEND);
  assign m_axis.tdata  = hold_q[DataW-1 -: 8];
  assign m_axis.tlast  = last_q & at_last;
  assign m_axis.tid    = id_q;
  assign m_axis.tdest  = dest_q;
  assign m_axis.tuser  = user_q;
  assign m_axis.tkeep  = '1;
  assign m_axis.tstrb  = '1;

  assign drop_count = cnt_q;

  logic unused_strobes;
  assign unused_strobes = ^{s_axis.tstrb, s_axis.tkeep};

endmodule

// File: tb/tb_axis_byte_serializer.sv
// Directed bench for axis_byte_serializer with IN_BYTES = 2 and DROP_IDLE = 1.
module tb_axis_byte_serializer;

  logic        clk;
  logic        arst;
  logic [15:0] drop_count;
  int          n_cmp;
  int          n_fail;

  axis #(.DATA_WIDTH_BYTES(2)) s_if ();
  axis #(.DATA_WIDTH_BYTES(1)) m_if ();

  axis_byte_serializer #(
    .IN_BYTES  (2),
    .DROP_IDLE (1'b1),
    .CNT_WIDTH (16)
  ) dut (
    .clk        (clk),
    .arst       (arst),
    .s_axis     (s_if),
    .m_axis     (m_if),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic l);
    s_if.tvalid = v;
    s_if.tdata  = d;
    s_if.tlast  = l;
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    obs = {m_if.tvalid, m_if.tlast, m_if.tdata};
    n_cmp++;
    if (obs !== 10'h000) begin
      n_fail++; $display("FAIL reset_out: got %h want %h", obs, 10'h000);
    end
    n_cmp++;
    if (s_if.tready !== 1'b1) begin
      n_fail++; $display("FAIL reset_tready: got %b want 1", s_if.tready);
    end
    n_cmp++;
    if (drop_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_drop_count: got %0d want 0", drop_count);
    end
    #10 arst = 1'b0;
    tick();
    n_cmp++;
    if (m_if.tvalid !== 1'b0 || s_if.tready !== 1'b1) begin
      n_fail++; $display("FAIL post_reset: got valid %b ready %b want 0 1", m_if.tvalid, s_if.tready);
    end
  endtask

  task automatic test_basic();
    logic [9:0] obs;
    s_if.tid = 4'h5; s_if.tdest = 4'hA; s_if.tuser = 1'b1;
    drive(1'b1, 16'h8123, 1'b0);
    tick();
    drive(1'b0, 16'h0000, 1'b0);
    s_if.tid = 4'h0; s_if.tdest = 4'h0; s_if.tuser = 1'b0;
    obs = {m_if.tvalid, m_if.tlast, m_if.tdata};
    n_cmp++;
    if (obs !== 10'h281) begin
      n_fail++; $display("FAIL basic_b0: got %h want %h", obs, 10'h281);
    end
    n_cmp++;
    if ({m_if.tid, m_if.tdest, m_if.tuser} !== 9'h0B5) begin
      n_fail++; $display("FAIL basic_side: got %h want %h", {m_if.tid, m_if.tdest, m_if.tuser}, 9'h0B5);
    end
    tick();
    obs = {m_if.tvalid, m_if.tlast, m_if.tdata};
    n_cmp++;
    if (obs !== 10'h223) begin
      n_fail++; $display("FAIL basic_b1: got %h want %h", obs, 10'h223);
    end
    tick();
    n_cmp++;
    if (m_if.tvalid !== 1'b0) begin
      n_fail++; $display("FAIL basic_idle: got valid %b want 0", m_if.tvalid);
    end
  endtask

  task automatic test_drop();
    logic [9:0] obs;
    drive(1'b1, 16'h0000, 1'b0);
    tick();
    n_cmp++;
    if (m_if.tvalid !== 1'b0 || drop_count !== 16'd1) begin
      n_fail++; $display("FAIL drop_filler: got valid %b cnt %0d want 0 1", m_if.tvalid, drop_count);
    end
    drive(1'b1, 16'h8055, 1'b1);
    tick();
    drive(1'b0, 16'h0000, 1'b0);
    obs = {m_if.tvalid, m_if.tlast, m_if.tdata};
    n_cmp++;
    if (obs !== 10'h280) begin
      n_fail++; $display("FAIL drop_b0: got %h want %h", obs, 10'h280);
    end
    tick();
    obs = {m_if.tvalid, m_if.tlast, m_if.tdata};
    n_cmp++;
    if (obs !== 10'h355 || drop_count !== 16'd1) begin
      n_fail++; $display("FAIL drop_b1: got %h cnt %0d want %h 1", obs, drop_count, 10'h355);
    end
    tick();
  endtask

  task automatic test_filler_last();
    logic [9:0] obs;
    drive(1'b1, 16'h0000, 1'b1);
    tick();
    drive(1'b0, 16'h0000, 1'b0);
    obs = {m_if.tvalid, m_if.tlast, m_if.tdata};
    n_cmp++;
    if (obs !== 10'h200) begin
      n_fail++; $display("FAIL filler_last_b0: got %h want %h", obs, 10'h200);
    end
    tick();
    obs = {m_if.tvalid, m_if.tlast, m_if.tdata};
    n_cmp++;
    if (obs !== 10'h300 || drop_count !== 16'd1) begin
      n_fail++; $display("FAIL filler_last_b1: got %h cnt %0d want %h 1", obs, drop_count, 10'h300);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [9:0] obs;
    logic [9:0] exp_obs [4];
    logic       exp_rdy [4];
    exp_obs = '{10'h280, 10'h201, 10'h280, 10'h202};
    exp_rdy = '{1'b0, 1'b1, 1'b0, 1'b1};
    drive(1'b1, 16'h8001, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) s_if.tdata = 16'h8002;
      if (i == 2) drive(1'b0, 16'h0000, 1'b0);
      obs = {m_if.tvalid, m_if.tlast, m_if.tdata};
      n_cmp++;
      if (obs !== exp_obs[i] || s_if.tready !== exp_rdy[i]) begin
        n_fail++;
        $display("FAIL b2b_%0d: got %h rdy %b want %h rdy %b", i, obs, s_if.tready, exp_obs[i], exp_rdy[i]);
      end
    end
    tick();
    n_cmp++;
    if (m_if.tvalid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle: got valid %b want 0", m_if.tvalid);
    end
  endtask

  task automatic test_drop_back_to_back();
    logic [9:0] obs;
    drive(1'b1, 16'h8001, 1'b0);
    tick();
    s_if.tdata = 16'h0000;
    tick();
    obs = {m_if.tvalid, m_if.tlast, m_if.tdata};
    n_cmp++;
    if (obs !== 10'h201 || s_if.tready !== 1'b1) begin
      n_fail++; $display("FAIL drop_b2b_b1: got %h rdy %b want %h 1", obs, s_if.tready, 10'h201);
    end
    tick();
    s_if.tdata = 16'h8002;
    n_cmp++;
    if (m_if.tvalid !== 1'b0 || drop_count !== 16'd2) begin
      n_fail++; $display("FAIL drop_b2b_drop: got valid %b cnt %0d want 0 2", m_if.tvalid, drop_count);
    end
    tick();
    drive(1'b0, 16'h0000, 1'b0);
    obs = {m_if.tvalid, m_if.tlast, m_if.tdata};
    n_cmp++;
    if (obs !== 10'h280) begin
      n_fail++; $display("FAIL drop_b2b_next: got %h want %h", obs, 10'h280);
    end
    tick();
    tick();
  endtask

  task automatic test_backpressure();
    logic [9:0] obs;
    drive(1'b1, 16'h8123, 1'b0);
    tick();
    drive(1'b0, 16'h0000, 1'b0);
    m_if.tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      obs = {m_if.tvalid, m_if.tlast, m_if.tdata};
      n_cmp++;
      if (obs !== 10'h281 || s_if.tready !== 1'b0) begin
        n_fail++; $display("FAIL stall_%0d: got %h rdy %b want %h 0", i, obs, s_if.tready, 10'h281);
      end
      tick();
    end
    m_if.tready = 1'b1;
    obs = {m_if.tvalid, m_if.tlast, m_if.tdata};
    n_cmp++;
    if (obs !== 10'h281) begin
      n_fail++; $display("FAIL stall_release: got %h want %h", obs, 10'h281);
    end
    tick();
    obs = {m_if.tvalid, m_if.tlast, m_if.tdata};
    n_cmp++;
    if (obs !== 10'h223) begin
      n_fail++; $display("FAIL stall_b1: got %h want %h", obs, 10'h223);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [9:0] obs;
    drive(1'b1, 16'h8123, 1'b1);
    tick();
    drive(1'b0, 16'h0000, 1'b0);
    #2 arst = 1'b1;
    #1;
    obs = {m_if.tvalid, m_if.tlast, m_if.tdata};
    n_cmp++;
    if (obs !== 10'h000 || drop_count !== 16'd0 || s_if.tready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_async: got %h cnt %0d rdy %b want 000 0 1", obs, drop_count, s_if.tready);
    end
    #2 arst = 1'b0;
    tick();
    n_cmp++;
    if (m_if.tvalid !== 1'b0 || m_if.tlast !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_flush: got valid %b last %b want 0 0", m_if.tvalid, m_if.tlast);
    end
    drive(1'b1, 16'h80AA, 1'b0);
    tick();
    drive(1'b0, 16'h0000, 1'b0);
    obs = {m_if.tvalid, m_if.tlast, m_if.tdata};
    n_cmp++;
    if (obs !== 10'h280) begin
      n_fail++; $display("FAIL rst_mid_b0: got %h want %h", obs, 10'h280);
    end
    tick();
    obs = {m_if.tvalid, m_if.tlast, m_if.tdata};
    n_cmp++;
    if (obs !== 10'h2AA) begin
      n_fail++; $display("FAIL rst_mid_b1: got %h want %h", obs, 10'h2AA);
    end
    tick();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    arst   = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    s_if.tid    = '0;
    s_if.tdest  = '0;
    s_if.tuser  = '0;
    s_if.tstrb  = '1;
    s_if.tkeep  = '1;
    m_if.tready = 1'b1;
    #2;
    test_reset();
    test_basic();
    test_drop();
    test_filler_last();
    test_back_to_back();
    test_drop_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_byte_serializer.md
# axis_byte_serializer

Downstream stage of the tlast-packetized processor output. It consumes multi-byte AXIS beats, where the MSB of each beat is the processor-valid flag and `tlast` closes a packet, and emits them as a 1-byte AXIS stream, MSB byte first, for byte-oriented host links (UART/FIFO bridges). Non-final filler beats (flag = 0, `tlast` = 0) can be dropped and counted. The last byte of every packet keeps its `tlast`.

## Interface
- `IN_BYTES`, default 2: width of `s_axis.tdata` in bytes. Must be ≥ 1.
- `DROP_IDLE`, default 1: when 1, non-final filler beats are consumed and never emitted.
- `CNT_WIDTH`, default 16: width of `drop_count`.

Ports, clock and reset first:
- `clk`, input, 1: sole clock; all logic is rising-edge.
- `arst`, input, 1: reset, asynchronous and active-high.
- `s_axis`, `axis.s`, DATA_WIDTH_BYTES = IN_BYTES: input beats. Uses `tvalid`, `tready`, `tdata`, `tlast`, `tid`, `tdest`, `tuser`. `tstrb` and `tkeep` are ignored.
- `m_axis`, `axis.m`, DATA_WIDTH_BYTES = 1: output bytes. `tkeep` and `tstrb` are tied to all-ones.
- `drop_count`, output, CNT_WIDTH: saturating count of dropped filler beats.

## Operation
- FSM has two states:
  - IDLE: holding register empty.
  - SEND: emitting bytes from the holding register.
- Accept rule: a beat is accepted when `s_axis.tvalid & s_axis.tready`.
  - `s_axis.tready` = IDLE, or (SEND & `m_axis.tready` & byte index = IN_BYTES-1).
  - This gives back-to-back acceptance with no bubble.
- On accept, let filler = `tdata[IN_BYTES*8-1]` == 0.
  - If DROP_IDLE & filler & !`tlast`: the beat is dropped. `drop_count` increments, saturating at all-ones. The next state is IDLE, or IDLE after the current last byte completes.
  - Otherwise: load `tdata`, `tlast`, `tid`, `tdest` and `tuser` into the holding register, set byte index = 0, next state SEND.
  - Filler beats with `tlast` = 1 are always emitted so the packet boundary survives.
- SEND:
  - `m_axis.tvalid` = 1.
  - `m_axis.tdata` = holding bits [IN_BYTES*8-1 -: 8]. Implement as a left-shift register that shifts by 8 bits per byte handshake.
  - `m_axis.tlast` = held `tlast` & (index = IN_BYTES-1).
  - `tid`, `tdest` and `tuser` come from the holding register.
- On a byte handshake:
  - If index < IN_BYTES-1: index increments.
  - Else, if a new non-dropped beat is accepted in the same cycle: reload and stay in SEND.
  - Else: go to IDLE.
- The index counter is $clog2(IN_BYTES) bits wide, minimum 1. It never wraps past IN_BYTES-1.
- IN_BYTES = 1 degenerates to a 1-deep register slice.

## Timing
- Reset values while `arst` is high and after release:
  - state IDLE, index 0, holding register 0.
  - `m_axis.tvalid` = 0, `m_axis.tdata` = 0, `m_axis.tlast` = 0.
  - `s_axis.tready` = 1.
  - `drop_count` = 0.
- Reset asserted mid-packet: remaining bytes are discarded and no `tlast` is emitted. `drop_count` clears.
- Latency: a beat accepted at edge N presents its first byte at N+1. All outputs are registered except `s_axis.tready`, which is combinational from state, index and `m_axis.tready`.
- Throughput with `m_axis.tready` held at 1: one beat per IN_BYTES cycles. A dropped beat costs 1 cycle in IDLE, or 0 extra cycles if it is accepted on the last-byte cycle.
- Backpressure: while `m_axis.tvalid` & !`m_axis.tready`, the values of `m_axis.tdata`, `tlast`, `tid`, `tdest` and `tuser` hold stable and `s_axis.tready` = 0 (AXIS rule).
- `m_axis.tvalid` never drops once asserted until the handshake completes.

## Structure
- Package `byte_serializer_config` holds:
  - `typedef enum logic {IDLE, SEND} ser_state_t`
  - `localparam IDX_WIDTH`
  - the filler-bit position function
- No sub-module: a single always_ff block plus the combinational `tready`/`tlast` logic.
- At top level, instantiate it directly on the `m_axis` of the tlast-packetized processor wrapper.

## Test plan
- IN_BYTES = 2, beat 0x8123 with `tlast` = 0, sink always ready → bytes 0x81 then 0x23 on consecutive cycles, both with `tlast` = 0, first byte one cycle after accept.
- DROP_IDLE = 1, beats 0x0000/`tlast`=0, then 0x8055/`tlast`=1 → only bytes 0x80, 0x55 are emitted, `tlast` is set on 0x55, and `drop_count` = 1.
- Beat 0x0000 with `tlast` = 1 → bytes 0x00, 0x00 with `tlast` on the second; `drop_count` unchanged.
- Back-to-back beats 0x8001, 0x8002 with valid held high and sink ready → 0x80, 0x01, 0x80, 0x02 in 4 consecutive cycles, and `s_axis.tready` high on the last-byte cycles.
- `m_axis.tready` low for 3 cycles during byte 0x81 of beat 0x8123 → `tdata`/`tlast` stay at 0x81/0 and `s_axis.tready` = 0 throughout; 0x23 follows after release.
- Assert `arst` after byte 0x81 of beat 0x8123/`tlast`=1 → `m_axis.tvalid` = 0 immediately (asynchronous); after release, no 0x23 and no `tlast`, and the next beat 0x80AA is emitted as 0x80, 0xAA.
